ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_sync.sv | 46 ++++
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host link: host transmit FSM states,
// frame edge numbering, command bytes and the parity helper.
// No ports; imported by ps2_host_tx and the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FINISH
    } state_t;

    // Device falling-edge numbering within one host-to-device frame.
    localparam logic [3:0] DATA_LAST   = 4'd8;
    localparam logic [3:0] PARITY_EDGE = 4'd9;
    localparam logic [3:0] STOP_EDGE   = 4'd10;
    localparam logic [3:0] ACK_EDGE    = 4'd11;

    // Common keyboard commands.
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int TIMER_W = 20;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
// Brings the asynchronous PS/2 clock and data lines into the CLOCK_50 domain
// and flags falling edges of the synchronised PS/2 clock.
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   asynchronous active-high reset
//   ps2_clk   in   raw PS/2 clock line
//   ps2_dat   in   raw PS/2 data line
//   clk_sync  out  synchronised PS/2 clock
//   dat_sync  out  synchronised PS/2 data
//   clk_fall  out  one-cycle flag: synchronised PS/2 clock went 1 -> 0
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // NOTE: the synchronisers reset to 1, the idle level of a pulled-up bus,
    // so leaving reset never fabricates a falling edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what forms the shift chain.
            clk_ff   <= {clk_ff[0], ps2_clk};
            dat_ff   <= {dat_ff[0], ps2_dat};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync = clk_ff[1];
    assign dat_sync = dat_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device: inhibit, request to
// send, shift 8 data bits + odd parity + stop on device clock edges, then
// check the device ACK and wait for the bus to go idle.
// Ports:
//   CLOCK_50  in     system clock
//   reset     in     asynchronous active-high reset
//   tx_data   in     byte to send, latched when tx_valid && tx_ready
//   tx_valid  in     send request
//   tx_ready  out    1 only while idle
//   tx_busy   out    1 while a transfer is in progress (receiver ignores bus)
//   tx_done   out    one-cycle pulse: device acknowledged, bus idle again
//   tx_error  out    one-cycle pulse: NACK or timeout
//   PS2_CLK   inout  open-drain PS/2 clock (driven 0 or released)
//   PS2_DAT   inout  open-drain PS/2 data  (driven 0 or released)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    // Each timed state lasts exactly its limit in cycles: the timer starts at
    // 0 on entry, so the exit decision is taken on count LIMIT-1.
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PACKET_LAST  = TIMER_W'(PACKET_TIMEOUT - 1);

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [3:0]           edge_cnt, edge_cnt_n;
    logic [7:0]           shift_q, shift_n;
    logic                 parity_q, parity_n;
    logic                 dat_low_q, dat_low_n;
    logic                 ok_q, ok_n;

    logic clk_sync, dat_sync, clk_fall;

    ps2_line_sync u_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_fall (clk_fall)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            edge_cnt  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            dat_low_q <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            edge_cnt  <= edge_cnt_n;
            shift_q   <= shift_n;
            parity_q  <= parity_n;
            dat_low_q <= dat_low_n;
            ok_q      <= ok_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold value first so that no branch
        // below can leave one unassigned and infer a latch.
        state_n    = state;
        edge_cnt_n = edge_cnt;
        shift_n    = shift_q;
        parity_n   = parity_q;
        dat_low_n  = dat_low_q;
        ok_n       = ok_q;

        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_n    = ST_INHIBIT;
                    shift_n    = tx_data;
                    parity_n   = odd_parity(tx_data);
                    edge_cnt_n = '0;
                    dat_low_n  = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (timer == INHIBIT_LAST) state_n = ST_RTS;
            end
            ST_RTS: begin
                // The first device edge already asks for data bit 0.
                if (clk_fall) begin
                    state_n    = ST_SHIFT;
                    edge_cnt_n = 4'd1;
                    dat_low_n  = ~shift_q[0];
                    shift_n    = shift_q >> 1;
                end else if (timer == START_LAST) begin
                    state_n = ST_FINISH;
                    ok_n    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    edge_cnt_n = edge_cnt + 4'd1;
                    if (edge_cnt_n <= DATA_LAST) begin
                        dat_low_n = ~shift_q[0];
                        shift_n   = shift_q >> 1;
                    end else if (edge_cnt_n == PARITY_EDGE) begin
                        dat_low_n = ~parity_q;
                    end else begin
                        // STOP_EDGE: release data for the stop bit.
                        dat_low_n = 1'b0;
                        state_n   = ST_ACK;
                    end
                end else if (timer == PACKET_LAST) begin
                    state_n = ST_FINISH;
                    ok_n    = 1'b0;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    edge_cnt_n = ACK_EDGE;
                    if (!dat_sync) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        state_n = ST_FINISH;
                        ok_n    = 1'b0;
                    end
                end else if (timer == PACKET_LAST) begin
                    state_n = ST_FINISH;
                    ok_n    = 1'b0;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    state_n = ST_FINISH;
                    ok_n    = 1'b1;
                end else if (timer == PACKET_LAST) begin
                    state_n = ST_FINISH;
                    ok_n    = 1'b0;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        // Timer restarts on any state change and saturates instead of wrapping.
        if (state_n != state)
            timer_n = '0;
        else if (&timer)
            timer_n = timer;
        else
            timer_n = timer + TIMER_W'(1);
    end

    // Outputs decode the asynchronously reset state directly, so asserting
    // reset releases the bus and clears the pulses without a clock edge.
    logic clk_drive_low, dat_drive_low;

    assign clk_drive_low = (state == ST_INHIBIT);
    assign dat_drive_low = (state == ST_RTS) || ((state == ST_SHIFT) && dat_low_q);

    assign PS2_CLK = clk_drive_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive_low ? 1'b0 : 1'bz;

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = (state == ST_FINISH) &&  ok_q;
    assign tx_error = (state == ST_FINISH) && !ok_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a small PS/2 device model that clocks
// the frame, records the bits the host drives, and ACKs or NACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 6;   // device clock half period in system cycles

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error;

    wire  ps2_clk, ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_tx #(
        .INHIBIT_CYCLES (10),
        .START_TIMEOUT  (50),
        .PACKET_TIMEOUT (2000)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int ready_hi = 0;
    bit in_xfer = 1'b0;

    logic [9:0] frame;     // [7:0] data, [8] parity, [9] stop as seen by device
    int         inh_len;
    bit         saw_done, saw_err;

    always @(negedge CLOCK_50) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (in_xfer && tx_ready === 1'b1) ready_hi++;
    end

    // Called at a negedge; the request is accepted on the next rising edge.
    task automatic start_send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        in_xfer  = 1'b1;
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL accept_%h: tx_busy=%b expected 1", d, tx_busy);
        end
    endtask

    // Counts cycles with PS2_CLK low, then checks the start bit of RTS.
    task automatic measure_inhibit;
        inh_len = 0;
        while (ps2_clk === 1'b0 && inh_len < 1000) begin
            inh_len++;
            @(negedge CLOCK_50);
        end
        total++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b0) begin
            bad++;
            $display("FAIL rts_start_bit: clk=%b dat=%b expected clk=1 dat=0", ps2_clk, ps2_dat);
        end
    endtask

    // Device generates n falling edges (n <= 10), sampling data at each rise.
    task automatic clock_edges(input int n, input bit poke);
        for (int k = 1; k <= n; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLOCK_50);
            frame[k-1]  = ps2_dat;
            dev_clk_low = 1'b0;
            if (poke && k == 5) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                @(negedge CLOCK_50);
                tx_valid = 1'b0;
                repeat (HALF - 1) @(negedge CLOCK_50);
            end else begin
                repeat (HALF) @(negedge CLOCK_50);
            end
        end
    endtask

    task automatic wait_pulse;
        int n = 0;
        while (tx_done !== 1'b1 && tx_error !== 1'b1 && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        saw_done = (tx_done === 1'b1);
        saw_err  = (tx_error === 1'b1);
        in_xfer  = 1'b0;
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL pulse_wait: no tx_done/tx_error within %0d cycles", n);
        end
        @(negedge CLOCK_50);
        total++;
        if (tx_done !== 1'b0 || tx_error !== 1'b0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL pulse_end: done=%b err=%b ready=%b expected 0 0 1",
                     tx_done, tx_error, tx_ready);
        end
    endtask

    // Full transfer with the device model; ack=0 leaves data high at edge 11.
    task automatic xfer(input logic [7:0] d, input bit ack, input bit poke);
        frame = '0;
        start_send(d);
        measure_inhibit;
        repeat (3) @(negedge CLOCK_50);
        clock_edges(10, poke);
        dev_dat_low = ack;
        dev_clk_low = 1'b1;
        if (ack) begin
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            dev_dat_low = 1'b0;
            wait_pulse;
        end else begin
            wait_pulse;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLOCK_50);
        total++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b expected 1 0 0 0",
                     tx_ready, tx_busy, tx_done, tx_error);
        end
        total++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            bad++;
            $display("FAIL reset_lines: clk=%b dat=%b expected 1 1", ps2_clk, ps2_dat);
        end
        reset = 1'b0;
    endtask

    task automatic test_send_ed;
        int d0 = done_cnt;
        int e0 = err_cnt;
        ready_hi = 0;
        @(negedge CLOCK_50);
        xfer(CMD_SET_LEDS, 1'b1, 1'b0);
        total++;
        if (inh_len != 10) begin
            bad++;
            $display("FAIL ed_inhibit_len: got %0d expected 10", inh_len);
        end
        total++;
        if (frame !== 10'b11_1110_1101) begin
            bad++;
            $display("FAIL ed_frame: got %b expected 1111101101", frame);
        end
        total++;
        if (!saw_done || saw_err || done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++;
            $display("FAIL ed_done: saw_done=%b saw_err=%b done_pulses=%0d err_pulses=%0d expected 1 0 1 0",
                     saw_done, saw_err, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_parity_zero;
        int d0 = done_cnt;
        @(negedge CLOCK_50);
        xfer(8'h07, 1'b1, 1'b0);
        total++;
        if (frame[8] !== 1'b0) begin
            bad++;
            $display("FAIL p07_parity: got %b expected 0", frame[8]);
        end
        total++;
        if (frame !== 10'b10_0000_0111) begin
            bad++;
            $display("FAIL p07_frame: got %b expected 1000000111", frame);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL p07_done: pulses=%0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_ignore_valid;
        int d0 = done_cnt;
        int d1;
        ready_hi = 0;
        @(negedge CLOCK_50);
        xfer(8'h00, 1'b1, 1'b1);
        total++;
        if (frame !== 10'b11_0000_0000) begin
            bad++;
            $display("FAIL z00_frame: got %b expected 1100000000", frame);
        end
        total++;
        if (ready_hi != 0) begin
            bad++;
            $display("FAIL z00_ready_low: ready high for %0d cycles expected 0", ready_hi);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL z00_done: pulses=%0d expected 1", done_cnt - d0);
        end
        d1 = done_cnt;
        repeat (20) @(negedge CLOCK_50);
        total++;
        if (ps2_clk !== 1'b1 || tx_ready !== 1'b1 || done_cnt != d1) begin
            bad++;
            $display("FAIL z00_no_queue: clk=%b ready=%b extra_done=%0d expected 1 1 0",
                     ps2_clk, tx_ready, done_cnt - d1);
        end
    endtask

    task automatic test_nack;
        int d0 = done_cnt;
        int e0 = err_cnt;
        @(negedge CLOCK_50);
        xfer(CMD_ENABLE, 1'b0, 1'b0);
        total++;
        if (frame !== 10'b10_1111_0100) begin
            bad++;
            $display("FAIL nack_frame: got %b expected 1011110100", frame);
        end
        total++;
        if (!saw_err || saw_done || err_cnt - e0 != 1 || done_cnt != d0) begin
            bad++;
            $display("FAIL nack_error: saw_err=%b saw_done=%b err_pulses=%0d done_pulses=%0d expected 1 0 1 0",
                     saw_err, saw_done, err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_start_timeout;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int n = 0;
        @(negedge CLOCK_50);
        start_send(8'h55);
        measure_inhibit;
        while (tx_error !== 1'b1 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        total++;
        if (n != 50) begin
            bad++;
            $display("FAIL start_timeout_cycles: got %0d expected 50", n);
        end
        total++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            bad++;
            $display("FAIL start_timeout_lines: clk=%b dat=%b expected 1 1", ps2_clk, ps2_dat);
        end
        in_xfer = 1'b0;
        @(negedge CLOCK_50);
        total++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_timeout_pulse: err_pulses=%0d done_pulses=%0d ready=%b expected 1 0 1",
                     err_cnt - e0, done_cnt - d0, tx_ready);
        end
    endtask

    task automatic test_reset_mid_transfer;
        int d0 = done_cnt;
        int e0 = err_cnt;
        @(negedge CLOCK_50);
        start_send(8'hE7);
        measure_inhibit;
        repeat (3) @(negedge CLOCK_50);
        clock_edges(5, 1'b0);
        total++;
        if (ps2_dat !== 1'b0) begin
            bad++;
            $display("FAIL rst_pre_dat: got %b expected 0 (bit 4 of E7)", ps2_dat);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_release: clk=%b dat=%b ready=%b busy=%b expected 1 1 1 0",
                     ps2_clk, ps2_dat, tx_ready, tx_busy);
        end
        in_xfer = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        total++;
        if (done_cnt != d0 || err_cnt != e0) begin
            bad++;
            $display("FAIL rst_no_pulse: done_pulses=%0d err_pulses=%0d expected 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        reset = 1'b0;
        xfer(CMD_RESET, 1'b1, 1'b0);
        total++;
        if (frame !== 10'b11_1111_1111) begin
            bad++;
            $display("FAIL rst_ff_frame: got %b expected 1111111111", frame);
        end
        total++;
        if (!saw_done || done_cnt - d0 != 1 || err_cnt != e0) begin
            bad++;
            $display("FAIL rst_ff_done: saw_done=%b done_pulses=%0d err_pulses=%0d expected 1 1 0",
                     saw_done, done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset;
        test_send_ed;
        test_parity_zero;
        test_ignore_valid;
        test_nack;
        test_start_timeout;
        test_reset_mid_transfer;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
